dma_io_arbiter: RTL and testbench

//  Two-channel DMA front end for the GPIO-interrupting I/O devices.

---
 rtl/dma_io_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_dma_io_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_io_arbiter.sv
// Two-channel DMA front end: round-robin grant between GPIO requesters, one-cycle ack,
// then a two-cycles-per-word burst from the granted device buffer into data memory.
module dma_io_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gpio1,
  input  logic              gpio2,
  input  logic [ADDR_W-1:0] cfg_base1,
  input  logic [ADDR_W-1:0] cfg_base2,
  input  logic [LEN_W-1:0]  cfg_len1,
  input  logic [LEN_W-1:0]  cfg_len2,
  input  logic [DATA_W-1:0] dev1_rdata,
  input  logic [DATA_W-1:0] dev2_rdata,
  output logic              ack1,
  output logic              ack2,
  output logic              dev_io_write,
  output logic [8:0]        dev1_index,
  output logic [8:0]        dev2_index,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              grant_id,
  output logic              done1,
  output logic              done2
);

  localparam int unsigned IDX_W = 9;
  localparam int unsigned OFF_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_RD,
    S_WR,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               ch_q, ch_d;
  logic               last_q, last_d;
  logic [1:0]         armed_q, armed_d;
  logic [1:0]         elig;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   cnt_inc;
  logic [1:0]         ack_q, ack_d;
  logic [1:0]         done_q, done_d;
  logic [IDX_W-1:0]   idx1_q, idx1_d;
  logic [IDX_W-1:0]   idx2_q, idx2_d;
  logic               we_q, we_d;
  logic               busy_q, busy_d;
  logic               rd_en;
  logic [OFF_W-1:0]   rd_off;
  logic [ADDR_W-1:0]  cfg_base_sel;
  logic [LEN_W-1:0]   cfg_len_sel;

  assign cfg_base_sel = ch_q ? cfg_base2 : cfg_base1;
  assign cfg_len_sel  = ch_q ? cfg_len2  : cfg_len1;
  assign elig         = {gpio2, gpio1} & armed_q;
  assign cnt_inc      = cnt_q + LEN_W'(1);

  // Next state and next registered outputs
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    last_d  = last_q;
    armed_d = armed_q | ~{gpio2, gpio1};
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ack_d   = 2'b00;
    done_d  = 2'b00;
    idx1_d  = '0;
    idx2_d  = '0;
    we_d    = 1'b0;
    rd_en   = 1'b0;
    rd_off  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (elig != 2'b00) begin
          ch_d    = (elig == 2'b11) ? ~last_q : elig[1];
          ack_d   = ch_d ? 2'b10 : 2'b01;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        base_d = cfg_base_sel;
        len_d  = cfg_len_sel;
        cnt_d  = '0;
        if (cfg_len_sel == '0) begin
          done_d  = ch_q ? 2'b10 : 2'b01;
          state_d = S_DONE;
        end else begin
          rd_en   = 1'b1;
          state_d = S_RD;
        end
      end
      S_RD: begin
        we_d    = 1'b1;
        addr_d  = base_q + ADDR_W'(cnt_q);
        state_d = S_WR;
      end
      S_WR: begin
        cnt_d = cnt_inc;
        if (cnt_inc == len_q) begin
          done_d  = ch_q ? 2'b10 : 2'b01;
          state_d = S_DONE;
        end else begin
          rd_en   = 1'b1;
          rd_off  = OFF_W'(cnt_inc);
          state_d = S_RD;
        end
      end
      S_DONE: begin
        last_d        = ch_q;
        armed_d[ch_q] = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_en) begin
      if (ch_q) idx2_d = {1'b1, rd_off};
      else      idx1_d = {1'b1, rd_off};
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= 1'b0;
      last_q  <= 1'b1;
      armed_q <= 2'b11;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      ack_q   <= 2'b00;
      done_q  <= 2'b00;
      idx1_q  <= '0;
      idx2_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      armed_q <= armed_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      idx1_q  <= idx1_d;
      idx2_q  <= idx2_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
    end
  end

  // Device data arrives in the write cycle, so it is forwarded straight to memory
  assign mem_wdata    = we_q ? (ch_q ? dev2_rdata : dev1_rdata) : '0;
  assign ack1         = ack_q[0];
  assign ack2         = ack_q[1];
  assign done1        = done_q[0];
  assign done2        = done_q[1];
  assign dev1_index   = idx1_q;
  assign dev2_index   = idx2_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign busy         = busy_q;
  assign grant_id     = ch_q;
  assign dev_io_write = 1'b0;

endmodule

// File: tb/tb_dma_io_arbiter.sv
// Randomized bench: a transaction-level model predicts ack/write/done events into a
// scoreboard queue, and a monitor compares them against what the arbiter presents.
module tb_dma_io_arbiter;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned LEN_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              gpio1 = 1'b0, gpio2 = 1'b0;
  logic [ADDR_W-1:0] cfg_base1 = '0, cfg_base2 = '0;
  logic [LEN_W-1:0]  cfg_len1 = '0, cfg_len2 = '0;
  logic [DATA_W-1:0] dev1_rdata = '0, dev2_rdata = '0;
  logic              ack1, ack2, dev_io_write, mem_we, busy, grant_id, done1, done2;
  logic [8:0]        dev1_index, dev2_index;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  dma_io_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .gpio1(gpio1), .gpio2(gpio2),
    .cfg_base1(cfg_base1), .cfg_base2(cfg_base2), .cfg_len1(cfg_len1), .cfg_len2(cfg_len2),
    .dev1_rdata(dev1_rdata), .dev2_rdata(dev2_rdata), .ack1(ack1), .ack2(ack2),
    .dev_io_write(dev_io_write), .dev1_index(dev1_index), .dev2_index(dev2_index),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .grant_id(grant_id), .done1(done1), .done2(done2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Device buffers: synchronous read, data valid the cycle after the index is presented
  logic [DATA_W-1:0] buf1 [32];
  logic [DATA_W-1:0] buf2 [32];
  always @(posedge clk) dev1_rdata <= dev1_index[8] ? buf1[dev1_index[4:0]] : DATA_W'($urandom);
  always @(posedge clk) dev2_rdata <= dev2_index[8] ? buf2[dev2_index[4:0]] : DATA_W'($urandom);

  typedef struct {
    int                cyc;
    int                kind;  // 0 ack, 1 memory write, 2 done
    int                ch;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Reference model state: one transaction in flight at most
  bit [1:0]          armed;
  int                last_ch;
  bit                active;
  int                t_k, t_done, t_ch, t_len;
  logic [ADDR_W-1:0] t_base;

  // Stimulus shadow values, applied at the next falling edge
  bit [1:0]          s_g;
  logic [ADDR_W-1:0] s_base [2];
  logic [LEN_W-1:0]  s_len  [2];

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endfunction

  function automatic void observe(input int kind, input int ch, input logic [ADDR_W-1:0] a,
                                  input logic [DATA_W-1:0] d, input int c);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event cyc=%0d got=kind%0d ch%0d exp=none", c, kind, ch);
      return;
    end
    e = exp_q.pop_front();
    chk("ev_cycle", 64'(c), 64'(e.cyc));
    chk("ev_kind", 64'(kind), 64'(e.kind));
    chk("ev_channel", 64'(ch), 64'(e.ch));
    if (kind == 1 && e.kind == 1) begin
      chk("mem_addr", 64'(a), 64'(e.addr));
      chk("mem_wdata", 64'(d), 64'(e.data));
    end
  endfunction

  function automatic void monitor(input int c);
    bit         bz;
    logic [8:0] e1, e2, ex;
    bz = active && (c > t_k) && ((c == t_k + 1) || (c <= t_done));
    chk("busy", 64'(busy), 64'(bz));
    chk("dev_io_write", 64'(dev_io_write), 64'(0));
    if (bz) chk("grant_id", 64'(grant_id), 64'(t_ch));
    e1 = '0;
    e2 = '0;
    if (bz && c >= t_k + 2 && c < t_done && ((c - t_k - 2) % 2 == 0)) begin
      ex = {1'b1, 8'((c - t_k - 2) / 2)};
      if (t_ch == 1) e2 = ex;
      else           e1 = ex;
    end
    chk("dev1_index", 64'(dev1_index), 64'(e1));
    chk("dev2_index", 64'(dev2_index), 64'(e2));
    while (exp_q.size() > 0 && exp_q[0].cyc < c) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_event cyc=%0d got=none exp=kind%0d ch%0d", exp_q[0].cyc,
               exp_q[0].kind, exp_q[0].ch);
      void'(exp_q.pop_front());
    end
    if (ack1)   observe(0, 0, '0, '0, c);
    if (ack2)   observe(0, 1, '0, '0, c);
    if (mem_we) observe(1, grant_id ? 1 : 0, mem_addr, mem_wdata, c);
    if (done1)  observe(2, 0, '0, '0, c);
    if (done2)  observe(2, 1, '0, '0, c);
  endfunction

  // Transaction-level rules: grant decided in cycle k, ack at k+1, config taken at k+1,
  // word i written at k+3+2i, done after the last word (or right after the ack for len 0).
  function automatic void model(input int c);
    bit [1:0] g, e;
    int       ch;
    g = {gpio2, gpio1};
    if (active && c == t_k + 1) begin
      t_base = (t_ch == 1) ? cfg_base2 : cfg_base1;
      t_len  = (t_ch == 1) ? int'(cfg_len2) : int'(cfg_len1);
      t_done = c + 1 + 2 * t_len;
      for (int i = 0; i < t_len; i++)
        exp_q.push_back('{c + 2 + 2 * i, 1, t_ch, ADDR_W'(t_base + ADDR_W'(i)),
                          (t_ch == 1) ? buf2[i] : buf1[i]});
      exp_q.push_back('{t_done, 2, t_ch, '0, '0});
    end
    if (active && c > t_k + 1 && c > t_done) active = 0;
    if (!active) begin
      e = g & armed;
      if (e != 2'b00) begin
        ch      = (e == 2'b11) ? 1 - last_ch : (e[1] ? 1 : 0);
        active  = 1;
        t_k     = c;
        t_ch    = ch;
        last_ch = ch;
        exp_q.push_back('{c + 1, 0, ch, '0, '0});
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (!g[i]) armed[i] = 1'b1;
      if (active && c > t_k + 1 && c == t_done && t_ch == i) armed[i] = 1'b0;
    end
  endfunction

  task automatic step();
    int c;
    @(negedge clk);
    c = cyc;
    monitor(c);
    gpio1     = s_g[0];
    gpio2     = s_g[1];
    cfg_base1 = s_base[0];
    cfg_base2 = s_base[1];
    cfg_len1  = s_len[0];
    cfg_len2  = s_len[1];
    model(c);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"}, 64'({ack1, ack2}), 64'(0));
    chk({tag, "_done"}, 64'({done1, done2}), 64'(0));
    chk({tag, "_we"}, 64'(mem_we), 64'(0));
    chk({tag, "_index"}, 64'({dev1_index, dev2_index}), 64'(0));
    chk({tag, "_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'(0));
    chk({tag, "_busy"}, 64'({busy, grant_id}), 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_g   = 2'b00;
    gpio1 = 1'b0;
    gpio2 = 1'b0;
    exp_q.delete();
    active  = 0;
    armed   = 2'b11;
    last_ch = 1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit reached;
    for (int i = 0; i < 32; i++) begin
      buf1[i] = $urandom;
      buf2[i] = $urandom;
    end
    s_base[0] = '0; s_base[1] = '0; s_len[0] = '0; s_len[1] = '0;
    do_reset();

    // Single three-word burst, then request held high afterwards (no re-grant)
    s_base[0] = ADDR_W'(100); s_len[0] = LEN_W'(3); s_g = 2'b01;
    run(20);
    s_g = 2'b00; run(3);

    // Simultaneous requests after reset: ch1 first, ch2 wraps past the top of memory
    do_reset();
    s_base[0] = ADDR_W'(40); s_len[0] = LEN_W'(2);
    s_base[1] = ADDR_W'(8190); s_len[1] = LEN_W'(4);
    s_g = 2'b11;
    run(30);
    s_g = 2'b00; run(2);
    s_g = 2'b11; run(30);
    s_g = 2'b00; run(2);

    // Zero-length request: ack then done, no memory write
    s_len[0] = '0; s_g = 2'b01; run(6);
    s_g = 2'b00; run(2);

    // Randomized requests with config churning every cycle
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 5) == 0) s_g[i] = ~s_g[i];
        s_base[i] = ($urandom_range(0, 3) == 0) ? ADDR_W'(8192 - $urandom_range(1, 4))
                                                 : ADDR_W'($urandom);
        s_len[i]  = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom)
                                                 : LEN_W'($urandom_range(0, 4));
      end
      step();
    end
    s_g = 2'b00; run(80);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    // Asynchronous reset during the write of word 2 of 5
    s_base[0] = ADDR_W'(500); s_len[0] = LEN_W'(5); s_g = 2'b01;
    reached = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (active && cyc == t_k + 5) begin
        reached = 1;
        break;
      end
    end
    chk("midburst_reached", 64'(reached), 64'(1));
    chk("midburst_we", 64'(mem_we), 64'(1));
    #2 rst_n = 1'b0;
    #1 check_zero("async");
    do_reset();
    run(12);
    chk("post_reset_idle", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
